// File: rtl/control_turnos_michi.sv
`default_nettype none
// ============================================================================
// Module      : control_turnos_michi
// Description : Turn controller / arbiter for tic-tac-toe (michi). Drives the
//               2:1 move mux select, validates and commits moves into the
//               3x3 boards it owns, and evaluates win/draw after every write.
// Revision    : 1.0 - initial release
// ============================================================================
module control_turnos_michi #(
    parameter int EMPIEZA_J1      = 1,
    parameter int ALTERNAR_INICIO = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_j1,
    input  logic [3:0] pos_j1,
    input  logic       btn_j2,
    input  logic [3:0] pos_j2,
    input  logic       nuevo_juego,
    output logic       sel,
    output logic [8:0] tablero_x,
    output logic [8:0] tablero_o,
    output logic       escribe,
    output logic       jugada_invalida,
    output logic [1:0] ganador,
    output logic       fin_juego
);

    localparam logic c_EMPIEZA  = (EMPIEZA_J1 != 0);
    localparam logic c_ALTERNAR = (ALTERNAR_INICIO != 0);

    localparam logic [2:0] c_J1_ESPERA  = 3'd0;
    localparam logic [2:0] c_J1_ESCRIBE = 3'd1;
    localparam logic [2:0] c_J2_ESPERA  = 3'd2;
    localparam logic [2:0] c_J2_ESCRIBE = 3'd3;
    localparam logic [2:0] c_EVALUA     = 3'd4;
    localparam logic [2:0] c_FIN        = 3'd5;

    logic [2:0] r_estado;
    logic [2:0] w_estado_sig;
    logic [8:0] r_x;
    logic [8:0] r_o;
    logic [8:0] r_celda;        // one-hot latched cell of the accepted move
    logic [3:0] r_cuenta;
    logic [1:0] r_ganador;
    logic       r_sel;
    logic       r_invalida;
    logic       r_inicio_j1;    // who started the current game

    logic [8:0] w_ocupadas;
    logic [8:0] w_celda_j1;
    logic [8:0] w_celda_j2;
    logic       w_valida_j1;
    logic       w_valida_j2;
    logic       w_inicio_sig;
    logic       w_gana;
    logic       w_fin_partida;

    // True when any of the 8 winning lines is fully occupied in board b
    function automatic logic hay_linea(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Positions 9..15 shift out of the 9-bit vector, so they never alias a cell
    assign w_ocupadas   = r_x | r_o;
    assign w_celda_j1   = 9'd1 << pos_j1;
    assign w_celda_j2   = 9'd1 << pos_j2;
    assign w_valida_j1  = (pos_j1 <= 4'd8) && ((w_celda_j1 & w_ocupadas) == 9'd0);
    assign w_valida_j2  = (pos_j2 <= 4'd8) && ((w_celda_j2 & w_ocupadas) == 9'd0);
    assign w_inicio_sig = c_ALTERNAR ? ~r_inicio_j1 : c_EMPIEZA;
    // sel still identifies the player who just moved while in EVALUA
    assign w_gana       = hay_linea(r_sel ? r_x : r_o);
    assign w_fin_partida = w_gana || (r_cuenta == 4'd9);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= c_EMPIEZA ? c_J1_ESPERA : c_J2_ESPERA;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state logic; a new-game request overrides any strobe
    always_comb begin
        w_estado_sig = r_estado;
        if (nuevo_juego) begin
            w_estado_sig = w_inicio_sig ? c_J1_ESPERA : c_J2_ESPERA;
        end else begin
            case (r_estado)
                c_J1_ESPERA:  if (btn_j1 && w_valida_j1) w_estado_sig = c_J1_ESCRIBE;
                c_J2_ESPERA:  if (btn_j2 && w_valida_j2) w_estado_sig = c_J2_ESCRIBE;
                c_J1_ESCRIBE: w_estado_sig = c_EVALUA;
                c_J2_ESCRIBE: w_estado_sig = c_EVALUA;
                c_EVALUA: begin
                    if (w_fin_partida)   w_estado_sig = c_FIN;
                    else if (r_sel)      w_estado_sig = c_J2_ESPERA;
                    else                 w_estado_sig = c_J1_ESPERA;
                end
                c_FIN:        w_estado_sig = c_FIN;
                default:      w_estado_sig = c_EMPIEZA ? c_J1_ESPERA : c_J2_ESPERA;
            endcase
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        escribe   = 1'b0;
        fin_juego = 1'b0;
        case (r_estado)
            c_J1_ESCRIBE, c_J2_ESCRIBE: escribe   = 1'b1;
            c_FIN:                      fin_juego = 1'b1;
            default: ;
        endcase
    end

    // Board, counter, result, error pulse and mux select datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x         <= 9'd0;
            r_o         <= 9'd0;
            r_celda     <= 9'd0;
            r_cuenta    <= 4'd0;
            r_ganador   <= 2'b00;
            r_sel       <= c_EMPIEZA;
            r_invalida  <= 1'b0;
            r_inicio_j1 <= c_EMPIEZA;
        end else begin
            r_invalida <= 1'b0;
            if (nuevo_juego) begin
                r_x         <= 9'd0;
                r_o         <= 9'd0;
                r_cuenta    <= 4'd0;
                r_ganador   <= 2'b00;
                r_inicio_j1 <= w_inicio_sig;
            end else begin
                case (r_estado)
                    c_J1_ESPERA: begin
                        if (btn_j1) begin
                            if (w_valida_j1) r_celda    <= w_celda_j1;
                            else             r_invalida <= 1'b1;
                        end
                    end
                    c_J2_ESPERA: begin
                        if (btn_j2) begin
                            if (w_valida_j2) r_celda    <= w_celda_j2;
                            else             r_invalida <= 1'b1;
                        end
                    end
                    c_J1_ESCRIBE: begin
                        r_x      <= r_x | r_celda;
                        r_cuenta <= r_cuenta + 4'd1;
                    end
                    c_J2_ESCRIBE: begin
                        r_o      <= r_o | r_celda;
                        r_cuenta <= r_cuenta + 4'd1;
                    end
                    c_EVALUA: begin
                        if (w_gana)                  r_ganador <= r_sel ? 2'b01 : 2'b10;
                        else if (r_cuenta == 4'd9)   r_ganador <= 2'b11;
                    end
                    default: ;
                endcase
            end
            // sel tracks the player on turn; it holds through EVALUA and FIN
            if (w_estado_sig == c_J1_ESPERA || w_estado_sig == c_J1_ESCRIBE) begin
                r_sel <= 1'b1;
            end else if (w_estado_sig == c_J2_ESPERA || w_estado_sig == c_J2_ESCRIBE) begin
                r_sel <= 1'b0;
            end
        end
    end

    assign sel             = r_sel;
    assign tablero_x       = r_x;
    assign tablero_o       = r_o;
    assign jugada_invalida = r_invalida;
    assign ganador         = r_ganador;

endmodule
`default_nettype wire

// File: tb/tb_control_turnos_michi.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_turnos_michi
// Description : Self-checking bench for control_turnos_michi using a
//               game-level reference model (cell array + line table).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_turnos_michi;

    localparam int c_EMP = 1;
    localparam int c_ALT = 1;
    localparam int c_LINEAS [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_j1 = 1'b0;
    logic [3:0] pos_j1 = 4'd0;
    logic       btn_j2 = 1'b0;
    logic [3:0] pos_j2 = 4'd0;
    logic       nuevo_juego = 1'b0;
    logic       sel;
    logic [8:0] tablero_x;
    logic [8:0] tablero_o;
    logic       escribe;
    logic       jugada_invalida;
    logic [1:0] ganador;
    logic       fin_juego;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cell owner 0/1/2, player on turn, result
    int m_celda [9];
    int m_turno, m_inicio, m_jug, m_gan;
    bit m_fin, m_sel;

    control_turnos_michi #(.EMPIEZA_J1(c_EMP), .ALTERNAR_INICIO(c_ALT)) dut (
        .clk(clk), .reset(reset),
        .btn_j1(btn_j1), .pos_j1(pos_j1),
        .btn_j2(btn_j2), .pos_j2(pos_j2),
        .nuevo_juego(nuevo_juego),
        .sel(sel), .tablero_x(tablero_x), .tablero_o(tablero_o),
        .escribe(escribe), .jugada_invalida(jugada_invalida),
        .ganador(ganador), .fin_juego(fin_juego)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic model_clear(input int starter);
        for (int i = 0; i < 9; i++) m_celda[i] = 0;
        m_inicio = starter; m_turno = starter; m_sel = (starter == 1);
        m_jug = 0; m_gan = 0; m_fin = 0;
    endtask

    task automatic modelo(input bit b1, input int p1, input bit b2, input int p2,
                          input bit nj, output bit e_esc, output bit e_inv);
        bit st; int p; bit linea;
        e_esc = 0; e_inv = 0;
        if (nj) begin
            model_clear(c_ALT != 0 ? 3 - m_inicio : (c_EMP != 0 ? 1 : 2));
        end else if (!m_fin) begin
            st = (m_turno == 1) ? b1 : b2;
            p  = (m_turno == 1) ? p1 : p2;
            if (st) begin
                if (p > 8)                 e_inv = 1;
                else if (m_celda[p] != 0)  e_inv = 1;
                else begin
                    e_esc = 1;
                    m_celda[p] = m_turno;
                    m_jug++;
                    linea = 0;
                    for (int l = 0; l < 8; l++)
                        if (m_celda[c_LINEAS[l][0]] == m_turno && m_celda[c_LINEAS[l][1]] == m_turno &&
                            m_celda[c_LINEAS[l][2]] == m_turno) linea = 1;
                    if (linea)            begin m_gan = m_turno; m_fin = 1; end
                    else if (m_jug == 9)  begin m_gan = 3;       m_fin = 1; end
                    else begin m_turno = 3 - m_turno; m_sel = (m_turno == 1); end
                end
            end
        end
    endtask

    // {escribe@N+1, invalida@N+1, late pulse, x, o, sel, ganador, fin_juego}
    function automatic logic [24:0] esperado(input bit e_esc, input bit e_inv);
        logic [8:0] ex, eo;
        ex = '0; eo = '0;
        for (int i = 0; i < 9; i++) begin
            ex[i] = (m_celda[i] == 1);
            eo[i] = (m_celda[i] == 2);
        end
        return {e_esc, e_inv, 1'b0, ex, eo, m_sel, m_gan[1:0], m_fin};
    endfunction

    // One transaction: strobe at edge N, observe through cycle N+3
    task automatic drive(input bit b1, input int p1, input bit b2, input int p2,
                         input bit nj, output logic [24:0] obs);
        logic e1, i1, late;
        @(negedge clk);
        btn_j1 = b1; pos_j1 = 4'(p1); btn_j2 = b2; pos_j2 = 4'(p2); nuevo_juego = nj;
        @(negedge clk);
        btn_j1 = 0; btn_j2 = 0; nuevo_juego = 0;
        e1 = escribe; i1 = jugada_invalida;
        @(negedge clk);
        late = escribe | jugada_invalida;
        @(negedge clk);
        late = late | escribe | jugada_invalida;
        obs = {e1, i1, late, tablero_x, tablero_o, sel, ganador, fin_juego};
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1;
        @(negedge clk); @(negedge clk); reset = 0;
        model_clear(c_EMP != 0 ? 1 : 2);
    endtask

    task automatic test_reset();
        logic [24:0] obs, exp_v; bit ee, ei;
        do_reset();
        obs = {escribe, jugada_invalida, 1'b0, tablero_x, tablero_o, sel, ganador, fin_juego};
        exp_v = esperado(0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_state: got %h need %h", obs, exp_v); end
        modelo(0, 0, 1, 0, 0, ee, ei);
        drive(0, 0, 1, 0, 0, obs);
        exp_v = esperado(ee, ei);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_j2_ignored: got %h need %h", obs, exp_v); end
    endtask

    // Directed move list: {player(1/2/3=both), pos1, pos2}
    task automatic test_moves(input string nombre, input int jug [$], input int posl [$]);
        logic [24:0] obs, exp_v; bit ee, ei, b1, b2;
        do_reset();
        for (int k = 0; k < jug.size(); k++) begin
            b1 = (jug[k] == 1) || (jug[k] == 3);
            b2 = (jug[k] == 2) || (jug[k] == 3);
            modelo(b1, posl[k], b2, (jug[k] == 3) ? posl[k] + 1 : posl[k], 0, ee, ei);
            drive(b1, posl[k], b2, (jug[k] == 3) ? posl[k] + 1 : posl[k], 0, obs);
            exp_v = esperado(ee, ei);
            n_cmp++;
            if (obs !== exp_v)
                begin n_err++; $display("FAIL %s step %0d: got %h need %h", nombre, k, obs, exp_v); end
        end
    endtask

    task automatic test_nuevo_juego();
        logic [24:0] obs, exp_v; bit ee, ei;
        do_reset();
        modelo(1, 4, 0, 0, 0, ee, ei); drive(1, 4, 0, 0, 0, obs);
        // new game with a simultaneous strobe: strobe dropped, P2 starts
        modelo(0, 0, 1, 5, 1, ee, ei); drive(0, 0, 1, 5, 1, obs);
        exp_v = esperado(ee, ei);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL nuevo_alterna: got %h need %h", obs, exp_v); end
        modelo(0, 0, 1, 5, 0, ee, ei); drive(0, 0, 1, 5, 0, obs);
        exp_v = esperado(ee, ei);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL nuevo_j2_mueve: got %h need %h", obs, exp_v); end
        modelo(1, 1, 0, 0, 1, ee, ei); drive(1, 1, 0, 0, 1, obs);
        exp_v = esperado(ee, ei);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL nuevo_vuelve_j1: got %h need %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_move();
        logic [24:0] obs, exp_v; logic e_mid;
        do_reset();
        @(negedge clk); btn_j1 = 1; pos_j1 = 4'd3;
        @(negedge clk); btn_j1 = 0; e_mid = escribe; reset = 1;
        @(negedge clk); reset = 0;
        model_clear(c_EMP != 0 ? 1 : 2);
        obs = {e_mid, jugada_invalida, escribe, tablero_x, tablero_o, sel, ganador, fin_juego};
        exp_v = esperado(1, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_mid_escribe: got %h need %h", obs, exp_v); end
    endtask

    task automatic test_random();
        logic [24:0] obs, exp_v; bit ee, ei, b1, b2, nj, ambos, quien;
        int p1, p2;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            nj    = m_fin ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            ambos = ($urandom_range(0, 7) == 0);
            quien = 1'($urandom_range(0, 1));
            b1 = quien | ambos;
            b2 = !quien | ambos;
            p1 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8);
            p2 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8);
            modelo(b1, p1, b2, p2, nj, ee, ei);
            drive(b1, p1, b2, p2, nj, obs);
            exp_v = esperado(ee, ei);
            n_cmp++;
            if (obs !== exp_v)
                begin n_err++; $display("FAIL random step %0d: got %h need %h", k, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        // P1 4; P2 4 occupied; P2 9 and 15 out of range; P1 strobe off-turn ignored
        test_moves("invalid", '{1, 2, 2, 2, 1}, '{4, 4, 9, 15, 0});
        // row 0 win for P1, then late strobes ignored in FIN
        test_moves("win_row", '{1, 2, 1, 2, 1, 1, 2}, '{0, 3, 1, 4, 2, 5, 6});
        // full board with no line -> draw
        test_moves("draw", '{1, 2, 1, 2, 1, 2, 1, 2, 1}, '{0, 2, 1, 3, 5, 4, 6, 7, 8});
        // ninth move completes diagonal 0-4-8 -> win, not draw
        test_moves("win_9th", '{1, 2, 1, 2, 1, 2, 1, 2, 1}, '{1, 2, 5, 3, 0, 6, 4, 7, 8});
        // both strobes together: only the player on turn is written
        test_moves("both_strobes", '{3, 3, 3}, '{2, 5, 7});
        test_nuevo_juego();
        test_reset_mid_move();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_turnos_michi.md
Name: control_turnos_michi

Overview:
- Turn controller and arbiter for the tic-tac-toe (michi) game.
- Shares the single move path, the 2:1 move multiplexer, between player 1 and player 2.
  - Drives the mux `sel`: 1 selects player 1 on input `uno`; 0 selects player 2 on input `cero`.
- Validates each move against the 3x3 board it owns, writes the move, and evaluates win or draw after every write.
- Sits between the debounced player inputs and the display/board logic.

Parameters:
- EMPIEZA_J1, 1, starting player after reset: 1 = player 1 (X), 0 = player 2 (O).
- ALTERNAR_INICIO, 1, when 1 each `nuevo_juego` hands the first move to the player who did not start the previous game.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- btn_j1  input  1  player 1 move strobe, one-cycle pulse (debounced upstream)
- pos_j1  input  4  player 1 cell index, 0..8, row-major
- btn_j2  input  1  player 2 move strobe, one-cycle pulse
- pos_j2  input  4  player 2 cell index, 0..8
- nuevo_juego  input  1  start-new-game pulse
- sel  output  1  mux select: 1 = player 1 path, 0 = player 2 path
- tablero_x  output  9  cells occupied by player 1, bit i = cell i
- tablero_o  output  9  cells occupied by player 2
- escribe  output  1  one-cycle pulse when a move is committed
- jugada_invalida  output  1  one-cycle pulse when a move is rejected
- ganador  output  2  00 in play, 01 player 1 wins, 10 player 2 wins, 11 draw
- fin_juego  output  1  high while the game is over

Behaviour:

States: J1_ESPERA, J1_ESCRIBE, J2_ESPERA, J2_ESCRIBE, EVALUA, FIN.

Reset:
- state = J1_ESPERA if EMPIEZA_J1 = 1, else J2_ESPERA.
- sel = EMPIEZA_J1.
- tablero_x = tablero_o = 0; escribe = jugada_invalida = 0.
- ganador = 00; fin_juego = 0; move counter = 0.
- Reset asserted in any state, mid-move included, wins over all other inputs on that edge.

Output `sel`:
- Registered; 1 in J1_* states, 0 in J2_* states.
- In EVALUA and FIN it holds its last value.

Jx_ESPERA:
- Only the strobe of the player on turn is looked at. The other player's strobe is ignored, with no error pulse; this also covers both strobes in the same cycle.
- On a strobe, the move is valid if pos <= 8 and the cell is empty in both boards.
  - Valid: latch pos and go to Jx_ESCRIBE.
  - Invalid: pulse `jugada_invalida` on the next cycle and stay in the state.

Jx_ESCRIBE (one cycle):
- Set the latched bit in tablero_x (player 1) or tablero_o (player 2).
- escribe = 1 for this cycle only; move counter +1.
- Next state: EVALUA.

EVALUA (one cycle, uses the updated registered boards):
- Checks the 8 win lines: rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonals {0,4,8}, {2,4,6}.
- Only the player who just moved is checked.
- Win: ganador = 01 or 10, go to FIN.
- No win and counter = 9: ganador = 11, go to FIN. A win on the 9th move reports the win, not a draw.
- Otherwise: go to the other player's ESPERA state.

Latency:
- Strobe accepted at cycle N.
- escribe high in cycle N+1; new board bit visible from N+2.
- ganador and fin_juego valid from N+3, the same edge `sel` flips for the next turn.

FIN:
- fin_juego = 1; all strobes ignored, no error pulses.

`nuevo_juego`:
- Honoured in any state except during reset.
- Clears both boards, the counter, ganador and fin_juego.
- Next state is the starting player's ESPERA, per EMPIEZA_J1 and ALTERNAR_INICIO; `sel` follows.
- If it arrives together with a strobe, `nuevo_juego` wins and the strobe is dropped.

Invariant: tablero_x & tablero_o == 0 at all times.

Test Plan:
- Reset with EMPIEZA_J1=1 -> sel=1, boards 000000000, ganador=00, fin_juego=0; btn_j2 pulse with pos_j2=0 -> no change, no error pulse.
- P1 plays cell 4 -> escribe high 1 cycle after the strobe, tablero_x=9'b000010000, sel=0 three cycles after the strobe; P2 then plays cell 4 -> jugada_invalida pulse, board unchanged, sel stays 0; P2 plays pos 9 or 15 -> jugada_invalida pulse.
- Moves P1 0, P2 3, P1 1, P2 4, P1 2 -> ganador=01 and fin_juego=1 three cycles after the last strobe; a later btn_j1 or btn_j2 -> no board change.
- Full game ending without a line (X:0,1,5,6,8 / O:2,3,4,7) -> ganador=11 after the 9th move; variant with the 9th move completing diagonal {0,4,8} -> ganador=01.
- btn_j1 and btn_j2 in the same cycle while P1 is on turn -> only the P1 move is written.
- ALTERNAR_INICIO=1: nuevo_juego after a game started by P1 -> boards 0, sel=0, state J2_ESPERA; reset asserted during J1_ESCRIBE -> no board bit set, all outputs at reset values.
